// File: rtl/simon_pkg.sv
// simon_pkg: constants and lookups shared by the SIMON key-schedule blocks.
//   Z_LEN          length of one z sequence period (62 bits)
//   Z_SEQ          z0..z4; Z_SEQ[k][61] is the first published bit of zk
//   ROUND_C        the constant 3 folded into every expanded key word
//   z_select(n,m)  z sequence index for a SIMON (N,M) pair, -1 if not a variant
//   rounds(n,m)    round count for a SIMON (N,M) pair, 0 if not a variant
//   sched_state_t  key scheduler FSM states
package simon_pkg;

  localparam int Z_LEN   = 62;
  localparam int ROUND_C = 3;

  // Written in published order, so the leftmost bit is z index 0.
  // Z_SEQ[0] is z0 because it is the last element of the concatenation.
  localparam logic [4:0][Z_LEN-1:0] Z_SEQ = {
    62'b11010001111001101011011000100000010111000011001010010011101111,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b11111010001001010110000111001101111101000100101011000011100110
  };

  typedef enum logic {IDLE, STREAM} sched_state_t;

  // Maps a word size / key word count pair onto its z sequence.
  function automatic int z_select(input int n, input int m);
    int sel;
    sel = -1;
    if ((n == 16 && m == 4) || (n == 24 && m == 3)) sel = 0;
    if (n == 24 && m == 4) sel = 1;
    if ((n == 32 && m == 3) || (n == 48 && m == 2) || (n == 64 && m == 2)) sel = 2;
    if ((n == 32 && m == 4) || (n == 48 && m == 3) || (n == 64 && m == 3)) sel = 3;
    if (n == 64 && m == 4) sel = 4;
    return sel;
  endfunction

  // Standard round count for each SIMON variant.
  function automatic int rounds(input int n, input int m);
    int r;
    r = 0;
    if (n == 16 && m == 4) r = 32;
    if (n == 24 && m == 3) r = 36;
    if (n == 24 && m == 4) r = 36;
    if (n == 32 && m == 3) r = 42;
    if (n == 32 && m == 4) r = 44;
    if (n == 48 && m == 2) r = 52;
    if (n == 48 && m == 3) r = 54;
    if (n == 64 && m == 2) r = 68;
    if (n == 64 && m == 3) r = 69;
    if (n == 64 && m == 4) r = 72;
    return r;
  endfunction

endpackage

// File: rtl/simon_key_round.sv
// simon_key_round: one combinational SIMON key-expansion step.
//   word0     oldest key word in the window (k[i])
//   word1     second window word (only mixed in when M == 4)
//   word_top  newest key word in the window (k[i+M-1])
//   zbit      z sequence bit for this round, placed at bit 0
//   next_word expanded key word k[i+M]
module simon_key_round
  import simon_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic [N-1:0] word0,
  input  logic [N-1:0] word1,
  input  logic [N-1:0] word_top,
  input  logic         zbit,
  output logic [N-1:0] next_word
);

  logic [N-1:0] rot3;
  logic [N-1:0] mixed;
  logic [N-1:0] spread;

  // Rotations are pure rewiring; the only logic is the XOR tree.
  always_comb begin
    rot3      = {word_top[2:0], word_top[N-1:3]};
    mixed     = (M == 4) ? (rot3 ^ word1) : rot3;
    spread    = mixed ^ {mixed[0], mixed[N-1:1]};
    next_word = ~word0 ^ spread ^ N'(ROUND_C) ^ {{(N-1){1'b0}}, zbit};
  end

endmodule

// File: rtl/simon_key_scheduler.sv
// simon_key_scheduler: streams the T SIMON round keys for one master key.
//   clk, rst   clock and synchronous active-high reset
//   key_valid  master key offered; key_ready high only while idle
//   key        master key words, key[0] is the first round key
//   rk_valid   round key present; rk_ready consumer accepts it
//   rk         current round key, rk_idx its round number (0..T-1)
//   rk_last    final round key of the stream is on rk
//   busy       a stream is in progress
module simon_key_scheduler
  import simon_pkg::*;
#(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int IW = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [M-1:0][N-1:0] key,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [N-1:0]        rk,
  output logic [IW-1:0]       rk_idx,
  output logic                rk_last,
  output logic                busy
);

  localparam int ZSEL     = z_select(N, M);
  localparam int ZROW_SEL = (ZSEL < 0) ? 0 : ZSEL;
  localparam logic [Z_LEN-1:0] Z_ROW   = Z_SEQ[ZROW_SEL];
  localparam logic [IW-1:0]    LAST_IDX = IW'(T - 1);

  // The package lookups return sentinels for non-SIMON shapes; refuse to build them.
  if (ZSEL < 0 || rounds(N, M) != T) begin : g_illegal_cfg
    $fatal(1, "simon_key_scheduler: illegal (N,M,T) = (%0d,%0d,%0d)", N, M, T);
  end

  sched_state_t         state;
  sched_state_t         state_next;
  logic [M-1:0][N-1:0]  window;
  logic [IW-1:0]        idx_q;
  logic [6:0]           zpos;
  logic [5:0]           zidx;
  logic                 zbit;
  logic [N-1:0]         next_word;
  logic                 load;
  logic                 beat;
  logic                 last_beat;

  assign load      = (state == IDLE) && key_valid;
  assign beat      = (state == STREAM) && rk_ready;
  assign last_beat = beat && (idx_q == LAST_IDX);

  // z sequences repeat every 62 rounds and T never exceeds 72, so a single
  // conditional subtract replaces a modulo.
  always_comb begin
    zpos = 7'(idx_q);
    if (zpos >= 7'd62) begin
      zpos = zpos - 7'd62;
    end
    zidx = 6'(7'd61 - zpos);
    zbit = Z_ROW[zidx];
  end

  simon_key_round #(
    .N(N),
    .M(M)
  ) u_round (
    .word0    (window[0]),
    .word1    (window[1]),
    .word_top (window[M-1]),
    .zbit     (zbit),
    .next_word(next_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: the accepted final beat returns to IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (load)      state_next = STREAM;
      STREAM:  if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Key window and round counter; the final beat leaves the window alone
  // and parks the counter at zero for the next key.
  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
      idx_q  <= '0;
    end else if (load) begin
      window <= key;
      idx_q  <= '0;
    end else if (last_beat) begin
      idx_q  <= '0;
    end else if (beat) begin
      for (int i = 0; i < M - 1; i++) begin
        window[i] <= window[i+1];
      end
      window[M-1] <= next_word;
      idx_q       <= idx_q + IW'(1);
    end
  end

  // Outputs depend on registered state only, so they hold through stalls.
  always_comb begin
    key_ready = (state == IDLE);
    rk_valid  = (state == STREAM);
    busy      = (state == STREAM);
    rk        = (state == STREAM) ? window[0] : '0;
    rk_idx    = idx_q;
    rk_last   = (state == STREAM) && (idx_q == LAST_IDX);
  end

endmodule

// File: tb/tb_simon_key_scheduler.sv
// tb_simon_key_scheduler: bench for simon_key_scheduler covering all ten
// SIMON variants, one instance per (N,M,T). Expected round keys come from a
// reference key schedule in this file and are queued when a key is loaded.
module tb_simon_key_scheduler;

  localparam int NCFG = 10;
  localparam int CFG_N [NCFG] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
  localparam int CFG_M [NCFG] = '{ 4,  3,  4,  3,  4,  2,  3,  2,  3,  4};
  localparam int CFG_T [NCFG] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
  localparam int CFG_Z [NCFG] = '{ 0,  0,  1,  2,  3,  2,  3,  2,  3,  4};

  localparam logic [61:0] Z_REF [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef struct {
    logic [63:0] rk;
    int          idx;
    logic        last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [255:0] key_bus;
  logic         key_valid_a [NCFG];
  logic         rk_ready_a  [NCFG];
  logic         key_ready_a [NCFG];
  logic         rk_valid_a  [NCFG];
  logic         rk_last_a   [NCFG];
  logic         busy_a      [NCFG];
  logic [63:0]  rk_a        [NCFG];
  logic [6:0]   idx_a       [NCFG];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int GN = CFG_N[g];
    localparam int GM = CFG_M[g];
    localparam int GT = CFG_T[g];
    logic [GM-1:0][GN-1:0]   key_l;
    logic [GN-1:0]           rk_l;
    logic [$clog2(GT)-1:0]   idx_l;

    assign key_l = key_bus[GM*GN-1:0];

    simon_key_scheduler #(
      .N(GN),
      .M(GM),
      .T(GT)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_valid(key_valid_a[g]),
      .key_ready(key_ready_a[g]),
      .key      (key_l),
      .rk_valid (rk_valid_a[g]),
      .rk_ready (rk_ready_a[g]),
      .rk       (rk_l),
      .rk_idx   (idx_l),
      .rk_last  (rk_last_a[g]),
      .busy     (busy_a[g])
    );

    assign rk_a[g]  = 64'(rk_l);
    assign idx_a[g] = 7'(idx_l);
  end

  function automatic logic [63:0] word_mask(input int n);
    return (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    return ((x >> r) | (x << (n - r))) & word_mask(n);
  endfunction

  // Reference key schedule: queues all T round keys for configuration c.
  task automatic push_expected(input int c, input logic [255:0] kv);
    logic [63:0] w [4];
    logic [63:0] tmp;
    logic [63:0] f;
    logic [63:0] mask;
    logic [61:0] zs;
    int n, m, t;
    n    = CFG_N[c];
    m    = CFG_M[c];
    t    = CFG_T[c];
    mask = word_mask(n);
    zs   = Z_REF[CFG_Z[c]];
    for (int i = 0; i < 4; i++) w[i] = (i < m) ? (64'(kv >> (i * n)) & mask) : 64'd0;
    for (int r = 0; r < t; r++) begin
      exp_q.push_back('{rk: w[0], idx: r, last: (r == t - 1)});
      tmp = ror(w[m-1], 3, n);
      if (m == 4) tmp = tmp ^ w[1];
      tmp = tmp ^ ror(tmp, 1, n);
      f   = (~w[0] ^ tmp ^ 64'(zs[61 - (r % 62)]) ^ 64'd3) & mask;
      for (int i = 0; i < m - 1; i++) w[i] = w[i+1];
      w[m-1] = f;
    end
  endtask

  function automatic logic [255:0] random_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers a key for exactly one cycle; caller guarantees the DUT is idle.
  task automatic load_key(input int c, input logic [255:0] kv);
    key_bus        = kv;
    key_valid_a[c] = 1'b1;
    @(posedge clk); #1;
    key_valid_a[c] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rk_valid_a[0] !== 1'b0 || key_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || rk_last_a[0] !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_ctrl got valid=%b ready=%b busy=%b last=%b expected 0 1 0 0",
        rk_valid_a[0], key_ready_a[0], busy_a[0], rk_last_a[0]); end
    checks++;
    if (rk_a[0] !== 64'd0 || idx_a[0] !== 7'd0)
      begin errors++; $display("[TB] FAIL reset_data got rk=%h idx=%0d expected rk=0 idx=0", rk_a[0], idx_a[0]); end
    for (int c = 1; c < NCFG; c++) begin
      checks++;
      if (rk_valid_a[c] !== 1'b0 || key_ready_a[c] !== 1'b1)
        begin errors++; $display("[TB] FAIL reset_cfg%0d got valid=%b ready=%b expected 0 1", c, rk_valid_a[c], key_ready_a[c]); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_stream();
    logic [15:0] known [5] = '{16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3};
    logic [255:0] kv = {192'd0, 64'h1918_1110_0908_0100};
    exp_t e;
    int got = 0;
    int cyc = 0;
    exp_q.delete();
    rk_ready_a[0] = 1'b1;
    push_expected(0, kv);
    load_key(0, kv);
    while (got < 32 && cyc < 100) begin
      checks++;
      if (rk_valid_a[0] !== 1'b1) begin
        errors++; $display("[TB] FAIL basic_valid beat=%0d got valid=%b expected 1", got, rk_valid_a[0]);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rk_a[0] !== e.rk || idx_a[0] !== 7'(e.idx) || rk_last_a[0] !== e.last)
          begin errors++; $display("[TB] FAIL basic_beat got rk=%h idx=%0d last=%b expected rk=%h idx=%0d last=%b",
            rk_a[0], idx_a[0], rk_last_a[0], e.rk, e.idx, e.last); end
        if (got < 5) begin
          checks++;
          if (rk_a[0] !== 64'(known[got]))
            begin errors++; $display("[TB] FAIL basic_vector idx=%0d got %h expected %h", got, rk_a[0], known[got]); end
        end
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (got != 32) begin errors++; $display("[TB] FAIL basic_count got %0d beats expected 32", got); end
    checks++;
    if (rk_valid_a[0] !== 1'b0 || key_ready_a[0] !== 1'b1)
      begin errors++; $display("[TB] FAIL basic_after got valid=%b ready=%b expected 0 1", rk_valid_a[0], key_ready_a[0]); end
    rk_ready_a[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [255:0] kv = {192'd0, 64'h1918_1110_0908_0100};
    exp_t e;
    logic [63:0] prev_rk = '0;
    logic [6:0]  prev_idx = '0;
    logic        prev_last = 1'b0;
    logic        prev_stall = 1'b0;
    logic        rdy;
    int got = 0;
    int cyc = 0;
    exp_q.delete();
    push_expected(0, kv);
    load_key(0, kv);
    while (got < 32 && cyc < 2000) begin
      rdy = 1'($urandom_range(0, 1));
      rk_ready_a[0] = rdy;
      if (prev_stall) begin
        checks++;
        if (rk_valid_a[0] !== 1'b1 || rk_a[0] !== prev_rk || idx_a[0] !== prev_idx || rk_last_a[0] !== prev_last)
          begin errors++; $display("[TB] FAIL stall_hold got valid=%b rk=%h idx=%0d last=%b expected 1 %h %0d %b",
            rk_valid_a[0], rk_a[0], idx_a[0], rk_last_a[0], prev_rk, prev_idx, prev_last); end
      end
      if (rk_valid_a[0] === 1'b1) begin
        if (rdy) begin
          e = exp_q.pop_front();
          checks++;
          if (rk_a[0] !== e.rk || idx_a[0] !== 7'(e.idx) || rk_last_a[0] !== e.last)
            begin errors++; $display("[TB] FAIL bp_beat got rk=%h idx=%0d last=%b expected rk=%h idx=%0d last=%b",
              rk_a[0], idx_a[0], rk_last_a[0], e.rk, e.idx, e.last); end
          got++;
        end
        prev_rk    = rk_a[0];
        prev_idx   = idx_a[0];
        prev_last  = rk_last_a[0];
        prev_stall = !rdy;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (got != 32 || exp_q.size() != 0)
      begin errors++; $display("[TB] FAIL bp_count got %0d beats (%0d left) expected 32", got, exp_q.size()); end
    checks++;
    if (rk_valid_a[0] !== 1'b0 || key_ready_a[0] !== 1'b1)
      begin errors++; $display("[TB] FAIL bp_after got valid=%b ready=%b expected 0 1", rk_valid_a[0], key_ready_a[0]); end
    rk_ready_a[0] = 1'b0;
  endtask

  task automatic test_z_wrap();
    logic [255:0] kv = {64'h1f1e1d1c1b1a1918, 64'h1716151413121110, 64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
    exp_t e;
    int got = 0;
    int cyc = 0;
    exp_q.delete();
    rk_ready_a[9] = 1'b1;
    push_expected(9, kv);
    load_key(9, kv);
    while (got < 72 && cyc < 200) begin
      checks++;
      if (rk_valid_a[9] !== 1'b1) begin
        errors++; $display("[TB] FAIL wrap_valid beat=%0d got valid=%b expected 1", got, rk_valid_a[9]);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rk_a[9] !== e.rk || idx_a[9] !== 7'(e.idx) || rk_last_a[9] !== e.last)
          begin errors++; $display("[TB] FAIL wrap_beat got rk=%h idx=%0d last=%b expected rk=%h idx=%0d last=%b",
            rk_a[9], idx_a[9], rk_last_a[9], e.rk, e.idx, e.last); end
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (got != 72) begin errors++; $display("[TB] FAIL wrap_count got %0d beats expected 72", got); end
    rk_ready_a[9] = 1'b0;
  endtask

  task automatic test_sweep();
    logic [255:0] kv;
    exp_t e;
    int got;
    int cyc;
    for (int c = 0; c < NCFG; c++) begin
      exp_q.delete();
      kv = random_key();
      got = 0;
      cyc = 0;
      rk_ready_a[c] = 1'b1;
      push_expected(c, kv);
      load_key(c, kv);
      while (got < CFG_T[c] && cyc < CFG_T[c] + 20) begin
        if (rk_valid_a[c] === 1'b1) begin
          e = exp_q.pop_front();
          checks++;
          if (rk_a[c] !== e.rk || idx_a[c] !== 7'(e.idx) || rk_last_a[c] !== e.last)
            begin errors++; $display("[TB] FAIL sweep_cfg%0d got rk=%h idx=%0d last=%b expected rk=%h idx=%0d last=%b",
              c, rk_a[c], idx_a[c], rk_last_a[c], e.rk, e.idx, e.last); end
          got++;
        end
        @(posedge clk); #1; cyc++;
      end
      checks++;
      if (got != CFG_T[c] || rk_valid_a[c] !== 1'b0)
        begin errors++; $display("[TB] FAIL sweep_len_cfg%0d got %0d beats valid_after=%b expected %0d beats valid_after=0",
          c, got, rk_valid_a[c], CFG_T[c]); end
      rk_ready_a[c] = 1'b0;
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [255:0] kv = random_key();
    exp_t e;
    int got = 0;
    int cyc = 0;
    exp_q.delete();
    rk_ready_a[0] = 1'b1;
    push_expected(0, kv);
    load_key(0, kv);
    while (got < 10 && cyc < 50) begin
      if (rk_valid_a[0] === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (rk_a[0] !== e.rk || idx_a[0] !== 7'(e.idx))
          begin errors++; $display("[TB] FAIL midrst_pre got rk=%h idx=%0d expected rk=%h idx=%0d", rk_a[0], idx_a[0], e.rk, e.idx); end
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (idx_a[0] !== 7'd10 || rk_valid_a[0] !== 1'b1)
      begin errors++; $display("[TB] FAIL midrst_at got idx=%0d valid=%b expected idx=10 valid=1", idx_a[0], rk_valid_a[0]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (rk_valid_a[0] !== 1'b0 || key_ready_a[0] !== 1'b1 || idx_a[0] !== 7'd0 || busy_a[0] !== 1'b0)
      begin errors++; $display("[TB] FAIL midrst_after got valid=%b ready=%b idx=%0d busy=%b expected 0 1 0 0",
        rk_valid_a[0], key_ready_a[0], idx_a[0], busy_a[0]); end
    exp_q.delete();
    kv  = random_key();
    got = 0;
    cyc = 0;
    push_expected(0, kv);
    load_key(0, kv);
    while (got < 32 && cyc < 100) begin
      if (rk_valid_a[0] === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (rk_a[0] !== e.rk || idx_a[0] !== 7'(e.idx) || rk_last_a[0] !== e.last)
          begin errors++; $display("[TB] FAIL midrst_fresh got rk=%h idx=%0d last=%b expected rk=%h idx=%0d last=%b",
            rk_a[0], idx_a[0], rk_last_a[0], e.rk, e.idx, e.last); end
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (got != 32) begin errors++; $display("[TB] FAIL midrst_count got %0d beats expected 32", got); end
    rk_ready_a[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [255:0] k1 = random_key();
    logic [255:0] k2 = random_key();
    exp_t e;
    int got;
    int cyc;
    exp_q.delete();
    rk_ready_a[0] = 1'b1;
    push_expected(0, k1);
    key_bus        = k1;
    key_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    key_bus = k2;
    for (int s = 0; s < 2; s++) begin
      got = 0;
      cyc = 0;
      while (got < 32 && cyc < 100) begin
        checks++;
        if (rk_valid_a[0] !== 1'b1 || key_ready_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
          errors++; $display("[TB] FAIL b2b_busy stream=%0d beat=%0d got valid=%b ready=%b busy=%b expected 1 0 1",
            s, got, rk_valid_a[0], key_ready_a[0], busy_a[0]);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rk_a[0] !== e.rk || idx_a[0] !== 7'(e.idx) || rk_last_a[0] !== e.last)
            begin errors++; $display("[TB] FAIL b2b_beat stream=%0d got rk=%h idx=%0d last=%b expected rk=%h idx=%0d last=%b",
              s, rk_a[0], idx_a[0], rk_last_a[0], e.rk, e.idx, e.last); end
          got++;
        end
        @(posedge clk); #1; cyc++;
      end
      checks++;
      if (got != 32) begin errors++; $display("[TB] FAIL b2b_count stream=%0d got %0d beats expected 32", s, got); end
      checks++;
      if (rk_valid_a[0] !== 1'b0 || key_ready_a[0] !== 1'b1)
        begin errors++; $display("[TB] FAIL b2b_gap stream=%0d got valid=%b ready=%b expected 0 1",
          s, rk_valid_a[0], key_ready_a[0]); end
      if (s == 0) begin
        push_expected(0, k2);
        @(posedge clk); #1;
        key_valid_a[0] = 1'b0;
      end
    end
    rk_ready_a[0] = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    key_bus = '0;
    for (int c = 0; c < NCFG; c++) begin
      key_valid_a[c] = 1'b0;
      rk_ready_a[c]  = 1'b0;
    end
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_z_wrap();
    test_sweep();
    test_reset_mid_stream();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
